// File: rtl/ram_port_arbiter.sv
// Shares the single-port RAM between fetch (F, read-only) and load/store (D); one access in flight, gnt next cycle, rdata RD_LAT cycles after gnt.
// Loser keeps req high and is served at the next IDLE decision; define RAM_ARB_RR_EN for round-robin ties (default: D over F).
module ram_port_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_mwrite,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state;
    logic       sel_d;
    logic       is_wr;
    logic [1:0] cnt;
    logic       pick_d;
    logic       resp_go;

`ifdef RAM_ARB_RR_EN
    logic last_d;
    assign pick_d = d_req && (!f_req || !last_d);
`else
    assign pick_d = d_req;
`endif

    // ram_out is valid on the edge that moves us into RESP
    assign resp_go = (state == ISSUE && !is_wr && RD_LAT == 1) ||
                     (state == WAIT && cnt == 2'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sel_d      <= 1'b0;
            is_wr      <= 1'b0;
            cnt        <= 2'd0;
            f_gnt      <= 1'b0;
            d_gnt      <= 1'b0;
            f_rvalid   <= 1'b0;
            d_rvalid   <= 1'b0;
            f_rdata    <= '0;
            d_rdata    <= '0;
            ram_addr   <= '0;
            ram_in     <= '0;
            ram_mwrite <= 1'b0;
            busy       <= 1'b0;
`ifdef RAM_ARB_RR_EN
            last_d     <= 1'b0;
`endif
        end else begin
            f_gnt      <= 1'b0;
            d_gnt      <= 1'b0;
            f_rvalid   <= 1'b0;
            d_rvalid   <= 1'b0;
            ram_mwrite <= 1'b0;
            case (state)
                IDLE: begin
                    if (f_req || d_req) begin
                        state    <= ISSUE;
                        sel_d    <= pick_d;
                        is_wr    <= pick_d && d_wr;
                        ram_addr <= pick_d ? d_addr : f_addr;
                        d_gnt    <= pick_d;
                        f_gnt    <= !pick_d;
                        busy     <= 1'b1;
                        if (pick_d && d_wr) begin
                            ram_in     <= d_wdata;
                            ram_mwrite <= 1'b1;
                        end
`ifdef RAM_ARB_RR_EN
                        last_d   <= pick_d;
`endif
                    end
                end
                ISSUE: begin
                    if (is_wr) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (RD_LAT > 1) begin
                        state <= WAIT;
                        cnt   <= 2'(RD_LAT - 2);
                    end else begin
                        state <= RESP;
                    end
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (resp_go) begin
                if (sel_d) begin
                    d_rdata  <= ram_out;
                    d_rvalid <= 1'b1;
                end else begin
                    f_rdata  <= ram_out;
                    f_rvalid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Three arbiters (RD_LAT 1,2,3) each with a RAM model; a cycle-stamped transaction model predicts every output each cycle.
module tb_ram_port_arbiter;
    localparam int NL = 3;

    logic          clk;
    logic [NL-1:0] rst, f_req, f_gnt, f_rvalid, d_req, d_wr, d_gnt, d_rvalid, ram_mwrite, busy;
    logic [7:0]    f_addr [NL];
    logic [7:0]    d_addr [NL];
    logic [7:0]    ram_addr [NL];
    logic [15:0]   d_wdata [NL];
    logic [15:0]   f_rdata [NL];
    logic [15:0]   d_rdata [NL];
    logic [15:0]   ram_in [NL];
    logic [15:0]   ram_out [NL];
    logic [15:0]   ram_mem [NL][256];
    logic [7:0]    apipe [NL][2];

    int ec = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int rvcnt [NL];
    bit gnt_ord [$];

    // transaction model: decision edge, winner, and the values the outputs must hold
    int          md [NL];
    bit          m_pd [NL];
    bit          m_wr [NL];
    logic [7:0]  m_addr [NL];
    int          m_free [NL];
    bit          m_last_d [NL];
    logic [7:0]  m_ram_addr [NL];
    logic [15:0] m_ram_in [NL];
    logic [15:0] m_frd [NL];
    logic [15:0] m_drd [NL];
    logic [15:0] m_mem [NL][256];

    for (genvar g = 0; g < NL; g++) begin : lane
        ram_port_arbiter #(.DATA_W(16), .ADDR_W(8), .RD_LAT(g + 1)) dut (
            .clk(clk), .reset(rst[g]),
            .f_req(f_req[g]), .f_addr(f_addr[g]), .f_gnt(f_gnt[g]),
            .f_rvalid(f_rvalid[g]), .f_rdata(f_rdata[g]),
            .d_req(d_req[g]), .d_wr(d_wr[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
            .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
            .ram_addr(ram_addr[g]), .ram_mwrite(ram_mwrite[g]), .ram_in(ram_in[g]),
            .ram_out(ram_out[g]), .busy(busy[g])
        );
        if (g == 0) begin : rd1
            assign ram_out[g] = ram_mem[g][ram_addr[g]];
        end else begin : rdn
            assign ram_out[g] = ram_mem[g][apipe[g][g-1]];
        end
    end

    function automatic logic [15:0] init_val(input int l, input int a);
        logic [7:0] b;
        b = 8'(a);
        if (a == 5 && l < 2) return 16'hA0B1;
        if (l == 2 && a == 'h30) return 16'h5A5A;
        return {b ^ 8'(l * 16), ~b};
    endfunction

    task automatic check(input string nm, input int l, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s lane%0d: got 0x%0h, required 0x%0h (t=%0t)", nm, l, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // RAM: asynchronous read of the address presented RD_LAT-1 edges earlier
    initial begin
        for (int l = 0; l < NL; l++) begin
            for (int a = 0; a < 256; a++) ram_mem[l][a] <= init_val(l, a);
            apipe[l][0] <= 8'h00;
            apipe[l][1] <= 8'h00;
        end
        forever begin
            @(posedge clk);
            for (int l = 0; l < NL; l++) begin
                if (ram_mwrite[l]) ram_mem[l][ram_addr[l]] <= ram_in[l];
                apipe[l][1] <= apipe[l][0];
                apipe[l][0] <= ram_addr[l];
            end
        end
    end

    task automatic model_step(input int l);
        bit pd;
        if (!rst[l]) begin
            md[l] = -1; m_free[l] = 0; m_last_d[l] = 0;
            m_ram_addr[l] = 0; m_ram_in[l] = 0; m_frd[l] = 0; m_drd[l] = 0;
        end else begin
            if (md[l] >= 0 && !m_wr[l] && ec == md[l] + l + 1) begin
                if (m_pd[l]) m_drd[l] = m_mem[l][m_addr[l]];
                else         m_frd[l] = m_mem[l][m_addr[l]];
            end
            if (ec >= m_free[l] && (f_req[l] || d_req[l])) begin
                if (f_req[l] && d_req[l]) begin
`ifdef RAM_ARB_RR_EN
                    pd = !m_last_d[l];
`else
                    pd = 1'b1;
`endif
                end else begin
                    pd = d_req[l];
                end
                md[l]         = ec;
                m_pd[l]       = pd;
                m_wr[l]       = pd && d_wr[l];
                m_addr[l]     = pd ? d_addr[l] : f_addr[l];
                m_ram_addr[l] = m_addr[l];
                if (m_wr[l]) begin
                    m_ram_in[l] = d_wdata[l];
                    m_mem[l][m_addr[l]] = d_wdata[l];
                end
                m_free[l]   = ec + 2 + (m_wr[l] ? 0 : l + 1);
                m_last_d[l] = pd;
            end
        end
    endtask

    initial begin
        for (int l = 0; l < NL; l++) begin
            md[l] = -1; m_free[l] = 0; m_last_d[l] = 0;
            m_ram_addr[l] = 0; m_ram_in[l] = 0; m_frd[l] = 0; m_drd[l] = 0;
            for (int a = 0; a < 256; a++) m_mem[l][a] = init_val(l, a);
        end
        forever begin
            @(posedge clk);
            ec = ec + 1;
            for (int l = 0; l < NL; l++) model_step(l);
        end
    end

    task automatic compare_lane(input int l);
        bit act, e_fg, e_dg, e_mw, e_frv, e_drv, e_busy;
        int lat;
        lat    = l + 1;
        act    = rst[l] && md[l] >= 0;
        e_fg   = act && ec == md[l] && !m_pd[l];
        e_dg   = act && ec == md[l] && m_pd[l];
        e_mw   = act && ec == md[l] && m_wr[l];
        e_frv  = act && !m_wr[l] && !m_pd[l] && ec == md[l] + lat;
        e_drv  = act && !m_wr[l] && m_pd[l] && ec == md[l] + lat;
        e_busy = act && ec >= md[l] && ec <= md[l] + (m_wr[l] ? 0 : lat);
        check("f_gnt", l, 32'(f_gnt[l]), 32'(e_fg));
        check("d_gnt", l, 32'(d_gnt[l]), 32'(e_dg));
        check("ram_mwrite", l, 32'(ram_mwrite[l]), 32'(e_mw));
        check("f_rvalid", l, 32'(f_rvalid[l]), 32'(e_frv));
        check("d_rvalid", l, 32'(d_rvalid[l]), 32'(e_drv));
        check("busy", l, 32'(busy[l]), 32'(e_busy));
        check("ram_addr", l, 32'(ram_addr[l]), rst[l] ? 32'(m_ram_addr[l]) : 32'd0);
        check("ram_in", l, 32'(ram_in[l]), rst[l] ? 32'(m_ram_in[l]) : 32'd0);
        check("f_rdata", l, 32'(f_rdata[l]), rst[l] ? 32'(m_frd[l]) : 32'd0);
        check("d_rdata", l, 32'(d_rdata[l]), rst[l] ? 32'(m_drd[l]) : 32'd0);
    endtask

    initial begin
        for (int l = 0; l < NL; l++) rvcnt[l] = 0;
        forever begin
            @(negedge clk);
            for (int l = 0; l < NL; l++) begin
                compare_lane(l);
                if (f_rvalid[l] || d_rvalid[l]) rvcnt[l]++;
            end
            if (d_gnt[0]) gnt_ord.push_back(1'b1);
            if (f_gnt[0]) gnt_ord.push_back(1'b0);
        end
    end

    task automatic wait_gnt(input int l, input bit pd);
        int t;
        bit g;
        t = 0;
        g = 1'b0;
        while (!g && t < 60) begin
            @(negedge clk);
            t++;
            g = pd ? d_gnt[l] : f_gnt[l];
        end
        check("gnt_seen", l, 32'(g), 32'd1);
    endtask

    task automatic access(input int l, input bit pd, input bit wr, input logic [7:0] a,
                          input logic [15:0] wd, output logic [7:0] ga, output logic mw,
                          output logic [15:0] gi, output logic [15:0] rd, output int lat);
        int g0, t;
        bit v;
        @(negedge clk);
        if (pd) begin
            d_req[l] = 1'b1; d_wr[l] = wr; d_addr[l] = a; d_wdata[l] = wd;
        end else begin
            f_req[l] = 1'b1; f_addr[l] = a;
        end
        wait_gnt(l, pd);
        ga = ram_addr[l]; mw = ram_mwrite[l]; gi = ram_in[l]; g0 = ec;
        d_req[l] = 1'b0;
        f_req[l] = 1'b0;
        rd = 16'h0;
        lat = -1;
        if (!wr) begin
            t = 0;
            v = 1'b0;
            while (!v && t < 20) begin
                @(negedge clk);
                t++;
                v = pd ? d_rvalid[l] : f_rvalid[l];
            end
            check("rvalid_seen", l, 32'(v), 32'd1);
            lat = ec - g0;
            rd = pd ? d_rdata[l] : f_rdata[l];
        end
    endtask

    // keeps req high across n back-to-back reads, moving the address after each grant
    task automatic stream(input int l, input bit pd, input int n, input logic [7:0] base);
        @(negedge clk);
        if (pd) begin
            d_req[l] = 1'b1; d_wr[l] = 1'b0; d_addr[l] = base;
        end else begin
            f_req[l] = 1'b1; f_addr[l] = base;
        end
        for (int k = 0; k < n; k++) begin
            wait_gnt(l, pd);
            if (pd) d_addr[l] = base + 8'(k + 1);
            else    f_addr[l] = base + 8'(k + 1);
        end
        if (pd) d_req[l] = 1'b0;
        else    f_req[l] = 1'b0;
    endtask

    function automatic int order_code();
        int v;
        v = 0;
        foreach (gnt_ord[i]) v = v * 2 + int'(gnt_ord[i]);
        return v;
    endfunction

    initial begin
        logic [7:0]  ga;
        logic        mw;
        logic [15:0] gi, rd;
        int          lat, rv0;
        rst = '1; f_req = '0; d_req = '0; d_wr = '0;
        for (int l = 0; l < NL; l++) begin
            f_addr[l] = 8'h00; d_addr[l] = 8'h00; d_wdata[l] = 16'h0000;
        end
        #1 rst = '0;
        repeat (3) @(negedge clk);
        rst = '1;

        access(0, 1'b0, 1'b0, 8'h05, 16'h0000, ga, mw, gi, rd, lat);
        check("fetch_addr", 0, 32'(ga), 32'h05);
        check("fetch_lat", 0, 32'(lat), 32'd1);
        check("fetch_data", 0, 32'(rd), 32'hA0B1);

        rv0 = rvcnt[0];
        access(0, 1'b1, 1'b1, 8'h10, 16'h1234, ga, mw, gi, rd, lat);
        check("store_mwrite", 0, 32'(mw), 32'd1);
        check("store_wdata", 0, 32'(gi), 32'h1234);
        check("store_addr", 0, 32'(ga), 32'h10);
        repeat (3) @(negedge clk);
        check("store_no_rvalid", 0, 32'(rvcnt[0] - rv0), 32'd0);
        access(0, 1'b1, 1'b0, 8'h10, 16'h0000, ga, mw, gi, rd, lat);
        check("load_back_lat", 0, 32'(lat), 32'd1);
        check("load_back_data", 0, 32'(rd), 32'h1234);

        access(2, 1'b1, 1'b0, 8'h30, 16'h0000, ga, mw, gi, rd, lat);
        check("lat3_addr", 2, 32'(ga), 32'h30);
        check("lat3_gnt_to_rvalid", 2, 32'(lat), 32'd3);
        check("lat3_data", 2, 32'(rd), 32'h5A5A);

        @(negedge clk);
        f_addr[1] = 8'h05;
        f_req[1] = 1'b1;
        wait_gnt(1, 1'b0);
        f_req[1] = 1'b0;
        @(posedge clk);
        #2 rst[1] = 1'b0;
        #1;
        check("rst_busy", 1, 32'(busy[1]), 32'd0);
        check("rst_ram_addr", 1, 32'(ram_addr[1]), 32'd0);
        check("rst_f_gnt", 1, 32'(f_gnt[1]), 32'd0);
        rv0 = rvcnt[1];
        repeat (2) @(negedge clk);
        rst[1] = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_no_rvalid", 1, 32'(rvcnt[1] - rv0), 32'd0);
        access(1, 1'b0, 1'b0, 8'h05, 16'h0000, ga, mw, gi, rd, lat);
        check("post_rst_lat", 1, 32'(lat), 32'd2);
        check("post_rst_data", 1, 32'(rd), 32'hA0B1);

        @(negedge clk);
        rst[0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b1;
        gnt_ord.delete();
        fork
            stream(0, 1'b1, 1, 8'h20);
            stream(0, 1'b0, 1, 8'h01);
        join
        repeat (4) @(negedge clk);
        check("tie_count", 0, 32'(gnt_ord.size()), 32'd2);
        check("tie_order", 0, 32'(order_code()), 32'b10);

        gnt_ord.delete();
        fork
            stream(0, 1'b1, 2, 8'h40);
            stream(0, 1'b0, 2, 8'h50);
        join
        repeat (6) @(negedge clk);
        check("held_count", 0, 32'(gnt_ord.size()), 32'd4);
`ifdef RAM_ARB_RR_EN
        check("held_order", 0, 32'(order_code()), 32'b1010);
`else
        check("held_order", 0, 32'(order_code()), 32'b1100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
